// File: rtl/modexp_pkg.sv
// modexp_pkg: shared FSM states and sizing helpers for modexp_engine and mod_mult
package modexp_pkg;
  typedef enum logic [2:0] {IDLE, PRERED, SQ, MUL, NEXT, FIN} state_t;
  function automatic int cnt_w(input int exp_width);
    return $clog2(2 * exp_width + 2);
  endfunction
  function automatic int mm_lat(input int width);
    return width + 1;
  endfunction
endpackage

// File: rtl/modexp_mod_mult.sv
// mod_mult: bit-serial interleaved p = a*b mod n, WIDTH+1 cycles from start to done pulse
// ports: clk, reset (active-low sync), start, a, b (<n), n (>=2) -> done (1-cycle pulse), p
module mod_mult import modexp_pkg::*; #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             done,
  output logic [WIDTH-1:0] p
);
  localparam int CW = $clog2(mm_lat(WIDTH));
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, n_q, n_d, p_q, p_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic done_q, done_d;
  logic [WIDTH+1:0] nx, t, t1;
  logic [WIDTH-1:0] t2;
  always_comb begin
    nx = {2'b00, n_q};
    // p < n keeps 2p + b < 3n, so two conditional subtracts fully reduce
    t = {1'b0, p_q, 1'b0} + (a_q[WIDTH-1] ? {2'b00, b_q} : '0);
    t1 = t >= nx ? t - nx : t;
    t2 = WIDTH'(t1 >= nx ? t1 - nx : t1);
    a_d = a_q;
    b_d = b_q;
    n_d = n_q;
    p_d = p_q;
    cnt_d = cnt_q;
    done_d = 1'b0;
    if (start) begin
      a_d = a;
      b_d = b;
      n_d = n;
      p_d = '0;
      cnt_d = CW'(WIDTH);
    end else if (cnt_q != '0) begin
      p_d = t2;
      a_d = a_q << 1;
      cnt_d = cnt_q - CW'(1);
      done_d = cnt_q == CW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_q <= '0;
      b_q <= '0;
      n_q <= '0;
      p_q <= '0;
      cnt_q <= '0;
      done_q <= 1'b0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      n_q <= n_d;
      p_q <= p_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
    end
  end
  assign done = done_q;
  assign p = p_q;
endmodule

// File: rtl/modexp_engine.sv
// modexp_engine: result = base^exponent mod modulus by left-to-right square-and-multiply
// ports: clk, reset (active-low sync), start, base, exponent, modulus -> busy, done, error, result, count
// MODEXP_LZ_SKIP_EN: when defined, leading zero exponent bits are skipped (latency/count only)
module modexp_engine import modexp_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int EXP_WIDTH = 16,
  parameter int CNT_W = cnt_w(EXP_WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     modulus,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [WIDTH-1:0]     result,
  output logic [CNT_W-1:0]     count
);
  localparam int IW = EXP_WIDTH > 1 ? $clog2(EXP_WIDTH) : 1;
  state_t state_q, state_d;
  logic first_q, first_d, busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [WIDTH-1:0] base_q, base_d, mod_q, mod_d, b_q, b_d, acc_q, acc_d, result_q, result_d;
  logic [EXP_WIDTH-1:0] exp_q, exp_d;
  logic [IW-1:0] idx_q, idx_d, top_idx;
  logic [CNT_W-1:0] count_q, count_d;
  logic mm_start, mm_done;
  logic [WIDTH-1:0] mm_a, mm_b, mm_p;
`ifdef MODEXP_LZ_SKIP_EN
  always_comb begin
    top_idx = '0;
    for (int i = 0; i < EXP_WIDTH; i++) if (exp_q[i]) top_idx = IW'(i);
  end
`else
  assign top_idx = IW'(EXP_WIDTH - 1);
`endif
  mod_mult #(.WIDTH(WIDTH)) u_mm (
    .clk(clk), .reset(reset), .start(mm_start),
    .a(mm_a), .b(mm_b), .n(mod_q), .done(mm_done), .p(mm_p)
  );
  // Each completion hands straight to the next issue in the same cycle, so the
  // NEXT step is evaluated inside SQ/MUL and never occupies a cycle of its own.
  always_comb begin
    state_d = state_q;
    first_d = first_q;
    busy_d = busy_q;
    done_d = 1'b0;
    error_d = error_q;
    base_d = base_q;
    exp_d = exp_q;
    mod_d = mod_q;
    b_d = b_q;
    acc_d = acc_q;
    idx_d = idx_q;
    result_d = result_q;
    count_d = count_q + CNT_W'(mm_done && count_q != '1);
    mm_start = 1'b0;
    mm_a = mm_p;
    mm_b = mm_p;
    case (state_q)
      IDLE: if (start) begin
        state_d = PRERED;
        base_d = base;
        exp_d = exponent;
        mod_d = modulus;
        first_d = 1'b1;
        busy_d = 1'b1;
        error_d = 1'b0;
        result_d = '0;
        count_d = '0;
      end
      PRERED: if (mod_q < WIDTH'(2)) begin
        state_d = FIN;
        acc_d = '0;
      end else if (first_q) begin
        first_d = 1'b0;
        mm_start = 1'b1;
        mm_a = base_q;
        mm_b = WIDTH'(1);
      end else if (mm_done) begin
        b_d = mm_p;
        acc_d = WIDTH'(1);
        idx_d = top_idx;
        mm_a = WIDTH'(1);
        mm_b = WIDTH'(1);
`ifdef MODEXP_LZ_SKIP_EN
        state_d = exp_q == '0 ? FIN : SQ;
        mm_start = exp_q != '0;
`else
        state_d = SQ;
        mm_start = 1'b1;
`endif
      end
      SQ: if (mm_done) begin
        acc_d = mm_p;
        if (exp_q[idx_q]) begin
          state_d = MUL;
          mm_start = 1'b1;
          mm_b = b_q;
        end else if (idx_q == '0) begin
          state_d = FIN;
        end else begin
          idx_d = idx_q - IW'(1);
          mm_start = 1'b1;
        end
      end
      MUL: if (mm_done) begin
        acc_d = mm_p;
        if (idx_q == '0) begin
          state_d = FIN;
        end else begin
          state_d = SQ;
          idx_d = idx_q - IW'(1);
          mm_start = 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
        done_d = 1'b1;
        busy_d = 1'b0;
        error_d = mod_q == '0;
        result_d = acc_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      first_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      error_q <= 1'b0;
      base_q <= '0;
      exp_q <= '0;
      mod_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      idx_q <= '0;
      result_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      busy_q <= busy_d;
      done_q <= done_d;
      error_q <= error_d;
      base_q <= base_d;
      exp_q <= exp_d;
      mod_q <= mod_d;
      b_q <= b_d;
      acc_q <= acc_d;
      idx_q <= idx_d;
      result_q <= result_d;
      count_q <= count_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign error = error_q;
  assign result = result_q;
  assign count = count_q;
endmodule

// File: tb/tb_modexp_engine.sv
// tb_modexp_engine: directed vector table plus abort/ignore sequences for modexp_engine
module tb_modexp_engine;
  localparam int W = 16;
  localparam int EW = 16;
  localparam int CW = $clog2(2 * EW + 2);
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [W-1:0] base = '0;
  logic [EW-1:0] exponent = '0;
  logic [W-1:0] modulus = '0;
  logic busy, done, error;
  logic [W-1:0] result;
  logic [CW-1:0] count;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [15:0] b;
    logic [15:0] e;
    logic [15:0] m;
    logic [15:0] res;
    logic err;
  } vec_t;
  vec_t vecs[12];
  modexp_engine #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clk(clk), .reset(reset), .start(start), .base(base), .exponent(exponent),
    .modulus(modulus), .busy(busy), .done(done), .error(error), .result(result), .count(count)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  function automatic int k_of(input logic [15:0] e);
    int pop = 0;
    int span = 0;
    for (int i = 0; i < EW; i++) begin
      pop += int'(e[i]);
`ifdef MODEXP_LZ_SKIP_EN
      if (e[i]) span = i + 1;
`else
      span = EW;
`endif
    end
    return 1 + span + pop;
  endfunction
  function automatic int exp_lat(input logic [15:0] e, input logic [15:0] m);
    return m < 16'd2 ? 2 : k_of(e) * (W + 1) + 2;
  endfunction
  function automatic int exp_cnt(input logic [15:0] e, input logic [15:0] m);
    return m < 16'd2 ? 0 : k_of(e);
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, want);
    end
  endtask
  task automatic run_op(input logic [15:0] b, input logic [15:0] e, input logic [15:0] m,
                        input int ign_at, output int lat, output logic [15:0] res,
                        output logic err, output int cnt);
    @(negedge clk);
    base = b;
    exponent = e;
    modulus = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    base = ~b;
    exponent = ~e;
    modulus = ~m;
    lat = 0;
    while (lat < 1000) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) chk("busy_after_accept", 32'(busy), 32'd1);
      if (done) break;
      start = lat == ign_at;
    end
    start = 1'b0;
    chk("done_seen", 32'(done), 32'd1);
    res = result;
    err = error;
    cnt = int'(count);
  endtask
  initial begin
    int lat, cnt;
    logic [15:0] res;
    logic err;
    logic seen;
    vecs[0]  = '{16'd4,     16'd13,    16'd497,   16'd445,   1'b0};
    vecs[1]  = '{16'd600,   16'd3,     16'd497,   16'd321,   1'b0};
    vecs[2]  = '{16'd5,     16'd0,     16'd7,     16'd1,     1'b0};
    vecs[3]  = '{16'd9,     16'd5,     16'd1,     16'd0,     1'b0};
    vecs[4]  = '{16'd9,     16'd5,     16'd0,     16'd0,     1'b1};
    vecs[5]  = '{16'd2,     16'd10,    16'd1000,  16'd24,    1'b0};
    vecs[6]  = '{16'd3,     16'd4,     16'd5,     16'd1,     1'b0};
    vecs[7]  = '{16'd65535, 16'd2,     16'd65521, 16'd196,   1'b0};
    vecs[8]  = '{16'd0,     16'd5,     16'd13,    16'd0,     1'b0};
    vecs[9]  = '{16'd2,     16'd15,    16'd65535, 16'd32768, 1'b0};
    vecs[10] = '{16'd3,     16'd3,     16'd2,     16'd1,     1'b0};
    vecs[11] = '{16'd1,     16'd65535, 16'd3,     16'd1,     1'b0};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    reset = 1'b1;
    foreach (vecs[i]) begin
      run_op(vecs[i].b, vecs[i].e, vecs[i].m, -1, lat, res, err, cnt);
      chk($sformatf("v%0d_result", i), 32'(res), 32'(vecs[i].res));
      chk($sformatf("v%0d_error", i), 32'(err), 32'(vecs[i].err));
      chk($sformatf("v%0d_count", i), 32'(cnt), 32'(exp_cnt(vecs[i].e, vecs[i].m)));
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(exp_lat(vecs[i].e, vecs[i].m)));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
      chk($sformatf("v%0d_result_held", i), 32'(result), 32'(vecs[i].res));
      chk($sformatf("v%0d_idle", i), 32'(busy), 32'd0);
    end
    run_op(16'd4, 16'd13, 16'd497, 50, lat, res, err, cnt);
    chk("ign_result", 32'(res), 32'd445);
    chk("ign_latency", 32'(lat), 32'(exp_lat(16'd13, 16'd497)));
    chk("ign_count", 32'(cnt), 32'(exp_cnt(16'd13, 16'd497)));
    @(negedge clk);
    base = 16'd4;
    exponent = 16'd13;
    modulus = 16'd497;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    chk("abort_busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_count", 32'(count), 32'd0);
    seen = 1'b0;
    repeat (400) begin
      @(posedge clk);
      #1;
      if (done || busy) seen = 1'b1;
    end
    chk("abort_quiet", 32'(seen), 32'd0);
    run_op(16'd600, 16'd3, 16'd497, -1, lat, res, err, cnt);
    chk("post_abort_result", 32'(res), 32'd321);
    chk("post_abort_count", 32'(cnt), 32'(exp_cnt(16'd3, 16'd497)));
    chk("post_abort_latency", 32'(lat), 32'(exp_lat(16'd3, 16'd497)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
